sgf_norm_round: RTL and testbench
=================================

SGF_NORM_ROUND -- requirements
Module: sgf_norm_round

Interface
- REQ-001 SHALL have parameter SW, default 24, meaning operand significand width including hidden bit; the Karatsuba multiplier product width is 2*SW.
- REQ-002 SHALL have parameter precision, default 0, meaning 0 = single (SW=24) and 1 = double (SW=53); it is carried for consistency with the multiplier and does not alter logic.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1, with reset synchronous and active-high.
- REQ-005 SHALL have port sgf_result_i, input, 2*SW, unsigned significand product from the multiplier, in the range [2^(2SW-2), 2^(2SW)).
- REQ-006 SHALL have port valid_i, input, 1; and ready_o, output, 1, forming the upstream handshake, where transfer occurs when both are 1.
- REQ-007 SHALL have port sgf_o, output, SW, the normalized and rounded significand with the hidden bit at bit SW-1.
- REQ-008 SHALL have port exp_inc_o, output, 2, the exponent adjustment 0, 1 or 2.
- REQ-009 SHALL have port inexact_o, output, 1, asserted when any discarded bit was nonzero.
- REQ-010 SHALL have port valid_o, output, 1; and ready_i, input, 1, forming the downstream handshake.

Function
- REQ-011 SHALL implement a two-stage pipeline, with S1 = normalize and capture guard/sticky, and S2 = round and output register; latency is 2 cycles from accepted input to valid_o when the path is unstalled.
- REQ-012 S1 normalize:
  - If sgf_result_i[2SW-1]=1: mantissa = [2SW-1:SW], guard = [SW-1], sticky = OR[SW-2:0], shift flag = 1.
  - Else: mantissa = [2SW-2:SW-1], guard = [SW-2], sticky = OR[SW-3:0], shift flag = 0.
- REQ-013 S2 round-to-nearest-even: increment when guard & (sticky | lsb).
- REQ-014 When the increment carries out (mantissa all ones), sgf_o SHALL be 1 followed by SW-1 zeros, and exp_inc_o = shift flag + 1.
- REQ-015 When the increment does not carry out, exp_inc_o SHALL equal the shift flag.
- REQ-016 inexact_o SHALL equal guard | sticky of the same datum.
- REQ-017 Stage advance rules:
  - S2 loads when ~valid_o | ready_i.
  - S1 loads when ~S1_valid | S2 loads.
  - ready_o equals the S1 load condition, and is combinational from ready_i.
- REQ-018 While valid_o=1 and ready_i=0, sgf_o, exp_inc_o, inexact_o and valid_o SHALL hold stable.
- REQ-019 Simultaneous input acceptance and output drain in the same cycle SHALL sustain one result per cycle with no bubble.
- REQ-020 A valid_i deasserted while ready_o=1 SHALL insert a bubble; bubbles SHALL never produce valid_o.
- REQ-021 Input data SHALL be ignored whenever valid_i=0 or ready_o=0.

Reset
- REQ-022 On rst=1 at a clock edge, both stage valid flags, valid_o, sgf_o, exp_inc_o and inexact_o SHALL clear to 0.
- REQ-023 Reset mid-operation SHALL discard all in-flight data with no output.
- REQ-024 ready_o SHALL be 1 in the cycle after reset.

Configuration
- REQ-025 Macro SGF_ROUND_MODE_EN, when defined, SHALL add input ports round_mode_i[1:0] and sign_i[0], both sampled with the datum and pipelined alongside it.
- REQ-026 Rounding modes under SGF_ROUND_MODE_EN:
  - 00 = RNE.
  - 01 = toward zero, which never increments.
  - 10 = toward +inf, which increments if (guard|sticky) & ~sign.
  - 11 = toward -inf, which increments if (guard|sticky) & sign.
- REQ-027 Without SGF_ROUND_MODE_EN, those ports SHALL be absent and the block SHALL round RNE only.

Structure
- REQ-028 Shared package sgf_pkg SHALL hold the round-mode encodings (RM_RNE, RM_RTZ, RM_RUP, RM_RDN) and the width constants for SW=24 and SW=53.
- REQ-029 The block SHALL contain one sub-module, sgf_round_inc, which is combinational: inputs are mantissa, guard, sticky and mode/sign; outputs are rounded mantissa, carry-out and inexact.

Verification (SW=24)
- REQ-030 Input 0x400000000000 (1.0*1.0) -> sgf_o=0x800000, exp_inc_o=0, inexact_o=0, with valid_o 2 cycles after acceptance.
- REQ-031 Input 0x400000400000 (exact tie, lsb 0) -> sgf_o=0x800000, exp_inc_o=0, inexact_o=1.
- REQ-032 Input 0x400000C00000 (tie, lsb 1) -> sgf_o=0x800002, exp_inc_o=0, inexact_o=1.
- REQ-033 Input 0xFFFFFFFFFFFF -> sgf_o=0x800000, exp_inc_o=2, inexact_o=1.
- REQ-034 Backpressure case:
  - Stimulus: 4 back-to-back inputs with ready_i held 0 for 5 cycles, then released.
  - Response: ready_o falls after 2 inputs are accepted; outputs hold stable; the 4 results emerge in order on consecutive cycles.
- REQ-035 Reset case:
  - Stimulus: rst asserted with 2 data in flight.
  - Response: valid_o=0 the next cycle; no stale result is ever emitted.

Source files
------------

// File: rtl/sgf_pkg.sv
// ============================================================================
// Module      : sgf_pkg
// Description : Shared rounding-mode encodings and significand widths.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sgf_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } round_mode_e;

    localparam int c_SW_SINGLE     = 24;
    localparam int c_SW_DOUBLE     = 53;
    localparam int c_PROD_W_SINGLE = 2 * c_SW_SINGLE;
    localparam int c_PROD_W_DOUBLE = 2 * c_SW_DOUBLE;

endpackage

`default_nettype wire

// File: rtl/sgf_round_inc.sv
// ============================================================================
// Module      : sgf_round_inc
// Description : Combinational rounding incrementer (RNE/RTZ/RUP/RDN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sgf_round_inc
    import sgf_pkg::*;
#(
    parameter int SW = 24
) (
    input  logic [SW-1:0] mant_i,
    input  logic          guard_i,
    input  logic          sticky_i,
    input  round_mode_e   mode_i,
    input  logic          sign_i,
    output logic [SW-1:0] mant_o,
    output logic          carry_o,
    output logic          inexact_o
);

    logic          w_inc;
    logic [SW:0]   w_sum;

    assign inexact_o = guard_i | sticky_i;

    always_comb begin
        w_inc = 1'b0;
        case (mode_i)
            RM_RNE:  w_inc = guard_i & (sticky_i | mant_i[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RUP:  w_inc = inexact_o & ~sign_i;
            RM_RDN:  w_inc = inexact_o & sign_i;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_sum   = {1'b0, mant_i} + {{SW{1'b0}}, w_inc};
    assign carry_o = w_sum[SW];
    // A carry-out means the mantissa overflowed to 2.0; renormalize to 1.0.
    assign mant_o  = carry_o ? {1'b1, {(SW-1){1'b0}}} : w_sum[SW-1:0];

endmodule

`default_nettype wire

// File: rtl/sgf_norm_round.sv
// ============================================================================
// Module      : sgf_norm_round
// Description : Two-stage normalize/round pipeline for multiplier significands.
//               Optional macro SGF_ROUND_MODE_EN adds directed rounding modes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sgf_norm_round
    import sgf_pkg::*;
#(
    parameter int SW        = 24,
    parameter int precision = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*SW-1:0] sgf_result_i,
    input  logic            valid_i,
    output logic            ready_o,
`ifdef SGF_ROUND_MODE_EN
    input  logic [1:0]      round_mode_i,
    input  logic [0:0]      sign_i,
`endif
    output logic [SW-1:0]   sgf_o,
    output logic [1:0]      exp_inc_o,
    output logic            inexact_o,
    output logic            valid_o,
    input  logic            ready_i
);

    if ((precision != 0) && (precision != 1)) begin : g_precision_check
        $error("sgf_norm_round: precision must be 0 or 1");
    end

    logic            w_s1_load;
    logic            w_s2_load;
    logic [SW-1:0]   w_norm_mant_d;
    logic            w_norm_guard_d;
    logic            w_norm_sticky_d;
    logic            w_norm_shift_d;

    logic            s1_valid_q;
    logic [SW-1:0]   s1_mant_q;
    logic            s1_guard_q;
    logic            s1_sticky_q;
    logic            s1_shift_q;

    round_mode_e     w_mode;
    logic            w_sign;
    logic [SW-1:0]   w_round_mant;
    logic            w_carry;
    logic            w_inexact;

    logic            valid_q;
    logic [SW-1:0]   sgf_q;
    logic [1:0]      exp_inc_q;
    logic            inexact_q;

    assign w_s2_load = ~valid_q | ready_i;
    assign w_s1_load = ~s1_valid_q | w_s2_load;
    assign ready_o   = w_s1_load;

    // Product lies in [1.0, 4.0): at most one position of left-justification.
    always_comb begin
        w_norm_shift_d = sgf_result_i[2*SW-1];
        if (w_norm_shift_d) begin
            w_norm_mant_d   = sgf_result_i[2*SW-1:SW];
            w_norm_guard_d  = sgf_result_i[SW-1];
            w_norm_sticky_d = |sgf_result_i[SW-2:0];
        end else begin
            w_norm_mant_d   = sgf_result_i[2*SW-2:SW-1];
            w_norm_guard_d  = sgf_result_i[SW-2];
            w_norm_sticky_d = |sgf_result_i[SW-3:0];
        end
    end

`ifdef SGF_ROUND_MODE_EN
    round_mode_e s1_mode_q;
    logic        s1_sign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_mode_q <= RM_RNE;
            s1_sign_q <= 1'b0;
        end else if (w_s1_load && valid_i) begin
            s1_mode_q <= round_mode_e'(round_mode_i);
            s1_sign_q <= sign_i[0];
        end
    end

    assign w_mode = s1_mode_q;
    assign w_sign = s1_sign_q;
`else
    assign w_mode = RM_RNE;
    assign w_sign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mant_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_shift_q  <= 1'b0;
        end else if (w_s1_load) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_mant_q   <= w_norm_mant_d;
                s1_guard_q  <= w_norm_guard_d;
                s1_sticky_q <= w_norm_sticky_d;
                s1_shift_q  <= w_norm_shift_d;
            end
        end
    end

    sgf_round_inc #(
        .SW (SW)
    ) u_round_inc (
        .mant_i    (s1_mant_q),
        .guard_i   (s1_guard_q),
        .sticky_i  (s1_sticky_q),
        .mode_i    (w_mode),
        .sign_i    (w_sign),
        .mant_o    (w_round_mant),
        .carry_o   (w_carry),
        .inexact_o (w_inexact)
    );

    // Bubbles advance the valid flag only, so output data never changes on them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            sgf_q     <= '0;
            exp_inc_q <= 2'b00;
            inexact_q <= 1'b0;
        end else if (w_s2_load) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sgf_q     <= w_round_mant;
                exp_inc_q <= {1'b0, s1_shift_q} + {1'b0, w_carry};
                inexact_q <= w_inexact;
            end
        end
    end

    assign valid_o   = valid_q;
    assign sgf_o     = sgf_q;
    assign exp_inc_o = exp_inc_q;
    assign inexact_o = inexact_q;

endmodule

`default_nettype wire

// File: tb/tb_sgf_norm_round.sv
// ============================================================================
// Module      : tb_sgf_norm_round
// Description : Self-checking bench for sgf_norm_round (SW=24) with a
//               scoreboard fed by an arithmetic rounding model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sgf_norm_round;

    localparam int SW = 24;

    typedef struct packed {
        logic [SW-1:0] sgf;
        logic [1:0]    e;
        logic          x;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*SW-1:0] sgf_result_i;
    logic            valid_i;
    logic            ready_o;
    logic [SW-1:0]   sgf_o;
    logic [1:0]      exp_inc_o;
    logic            inexact_o;
    logic            valid_o;
    logic            ready_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t q[$];
    logic hold_pending = 1'b0;
    res_t snap;

    always #5 clk = ~clk;

    sgf_norm_round #(
        .SW        (SW),
        .precision (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sgf_result_i (sgf_result_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
`ifdef SGF_ROUND_MODE_EN
        .round_mode_i (2'b00),
        .sign_i       (1'b0),
`endif
        .sgf_o        (sgf_o),
        .exp_inc_o    (exp_inc_o),
        .inexact_o    (inexact_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: truncate to SW bits, compare the remainder against one half ulp.
    function automatic res_t model(input logic [2*SW-1:0] p);
        longint unsigned pv, m, rem, half, unit;
        int              sh;
        res_t            r;
        pv = 64'(p);
        sh = (pv >= (64'd1 << (2*SW-1))) ? 1 : 0;
        unit = 64'd1 << (SW - 1 + sh);
        half = unit / 2;
        m    = pv / unit;
        rem  = pv % unit;
        if (rem > half || (rem == half && (m % 2) == 1))
            m = m + 1;
        if (m == (64'd1 << SW)) begin
            m  = m / 2;
            sh = sh + 1;
        end
        r.sgf = m[SW-1:0];
        r.e   = 2'(sh);
        r.x   = (rem != 0);
        return r;
    endfunction

    function automatic logic [2*SW-1:0] gen_data();
        logic [63:0] r64;
        logic [22:0] r23;
        logic [21:0] r22;
        logic [2*SW-1:0] d;
        r64 = {$urandom(), $urandom()};
        r23 = 23'($urandom());
        r22 = 22'($urandom());
        case ($urandom_range(0, 7))
            0: d = 48'hFFFF_FFFF_FFFF;
            1: d = {1'b1, r23, 1'b1, 23'd0};
            2: d = {2'b01, r23, 1'b1, 22'd0};
            3: d = {1'b0, 24'hFF_FFFF, 1'b1, r22};
            default: begin
                d = r64[47:0];
                if (d[47:46] == 2'b00) d[46] = 1'b1;
            end
        endcase
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid",   64'(valid_o),   64'd1);
                check("hold_sgf",     64'(sgf_o),     64'(snap.sgf));
                check("hold_exp",     64'(exp_inc_o), 64'(snap.e));
                check("hold_inexact", 64'(inexact_o), 64'(snap.x));
            end
            if (valid_o) begin
                if (q.size() == 0) begin
                    check("stale_output", 64'(valid_o), 64'd0);
                end else if (ready_i) begin
                    res_t e;
                    e = q.pop_front();
                    check("sb_sgf",     64'(sgf_o),     64'(e.sgf));
                    check("sb_exp",     64'(exp_inc_o), 64'(e.e));
                    check("sb_inexact", 64'(inexact_o), 64'(e.x));
                end
            end
            hold_pending = valid_o && !ready_i;
            snap = '{sgf: sgf_o, e: exp_inc_o, x: inexact_o};
            if (valid_i && ready_o) q.push_back(model(sgf_result_i));
        end
    end

    // Presents d until ready_o is seen, returns just after the accepting edge.
    task automatic send(input logic [2*SW-1:0] d);
        int waited = 0;
        valid_i      = 1'b1;
        sgf_result_i = d;
        @(negedge clk);
        while (!ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) check("send_timeout", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [2*SW-1:0] d,
                            input logic [SW-1:0] es, input logic [1:0] ee, input logic ex);
        send(d);
        valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 64'(valid_o), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_lat2"},    64'(valid_o),   64'd1);
        check({tag, "_sgf"},     64'(sgf_o),     64'(es));
        check({tag, "_exp"},     64'(exp_inc_o), 64'(ee));
        check({tag, "_inexact"}, 64'(inexact_o), 64'(ex));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2*SW-1:0] bp_data [4];
        int              accepted;

        rst          = 1'b1;
        valid_i      = 1'b0;
        ready_i      = 1'b1;
        sgf_result_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   64'(valid_o),   64'd0);
        check("rst_sgf",     64'(sgf_o),     64'd0);
        check("rst_exp",     64'(exp_inc_o), 64'd0);
        check("rst_inexact", 64'(inexact_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;

        directed("one_x_one",  48'h4000_0000_0000, 24'h800000, 2'd0, 1'b0);
        directed("tie_even",   48'h4000_0040_0000, 24'h800000, 2'd0, 1'b1);
        directed("tie_odd",    48'h4000_00C0_0000, 24'h800002, 2'd0, 1'b1);
        directed("all_ones",   48'hFFFF_FFFF_FFFF, 24'h800000, 2'd2, 1'b1);

        // Backpressure: four back-to-back inputs against a stalled sink.
        for (int i = 0; i < 4; i++) bp_data[i] = gen_data();
        ready_i  = 1'b0;
        accepted = 0;
        valid_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sgf_result_i = bp_data[accepted];
            @(negedge clk);
            if (ready_o) accepted++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(accepted), 64'd2);
        @(negedge clk);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        ready_i      = 1'b1;
        sgf_result_i = bp_data[2];
        @(negedge clk);
        check("bp_out0", 64'(valid_o), 64'd1);
        check("bp_rdy0", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        sgf_result_i = bp_data[3];
        @(negedge clk);
        check("bp_out1", 64'(valid_o), 64'd1);
        check("bp_rdy1", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_out2", 64'(valid_o), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_out3", 64'(valid_o), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_done", 64'(valid_o), 64'd0);
        check("bp_sb_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset with two data in flight.
        ready_i = 1'b0;
        send(gen_data());
        send(gen_data());
        valid_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("no_stale", 64'(valid_o), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random bubbles and stalls.
        for (int c = 0; c < 400; c++) begin
            valid_i      = ($urandom_range(0, 3) != 0);
            ready_i      = ($urandom_range(0, 3) != 0);
            sgf_result_i = gen_data();
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_valid", 64'(valid_o),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
